fact_core: RTL
==============

Name: fact_core

Overview:
- Iterative factorial engine: computes Result = n! for an unsigned input n using one multiply per cycle.
- Sits directly upstream of the factorial result, done and error holding registers. Those registers consume Result, Done and Err.
- Driven by the accelerator's Go pulse.

Parameters:
- W, 32, width of Result and of the product register
- NW, 4, width of input n
- MAX_N, 12, largest n whose factorial fits in W bits; used for error detection when the optional feature is absent

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Go  input  1  start request, sampled on Clk rising edge
- N  input  NW  operand n, sampled with Go
- Busy  output  1  high while computing (state CALC)
- Done  output  1  high in state DONE
- Err  output  1  overflow flag; valid while Done=1
- Result  output  W  n!, valid while Done=1; 0 on error

Behaviour:
- One clock (Clk). Reset (Rst) is asynchronous and active-high.
- Reset: state=IDLE, cnt=0, prod=0, err=0. All outputs 0 (Busy=0, Done=0, Err=0, Result=0).
- State register encodes IDLE, CALC, DONE. Done=(state==DONE), Busy=(state==CALC); both are decoded from the state register only. Err is a registered flag. Result is the prod register.
- IDLE, Go=1 at edge k (base case):
  - cnt<=N, prod<=1, err<=0.
  - Next state CALC.
  - Exception: N>MAX_N sends the block straight to DONE instead; see error rule below.
- CALC, each edge:
  - If cnt<=1: next state DONE. prod is held.
  - Otherwise: prod<=prod*cnt, truncated to W bits; cnt<=cnt-1.
- Latency: Done rises in the cycle after edge k+max(N,1).
  - N=0 and N=1 both give Result=1 after edge k+1.
  - N=5 gives Done after edge k+5.
- DONE:
  - Done, Err and Result are held indefinitely.
  - Go=1 restarts exactly as from IDLE, same edge behaviour. This gives back-to-back operation with no IDLE cycle.
- Go while in CALC is ignored. N changes during CALC have no effect; cnt is the only source.
- Go is level-sampled. Go held high restarts the block at every DONE edge.
- Error rule without the feature: N>MAX_N sampled at edge k gives state<=DONE, err<=1, prod<=0. Done=Err=1 in the cycle after edge k; no CALC cycles.
- Rst asserted mid-CALC or in DONE aborts immediately to the reset values. Operation resumes at the first Go after Rst deasserts.
- Multiplier: W x NW unsigned, combinational, single cycle. Only the low W bits are kept unless the feature is enabled.

Optional Feature:
- Macro: FACT_CORE_OVF_DETECT_EN
- Defined:
  - The MAX_N compare is removed.
  - Each CALC step forms the full (W+NW)-bit product.
  - If any bit above W-1 is nonzero: next state DONE, err<=1, prod<=0, cnt held.
  - Detects overflow for any W without a hand-set MAX_N.
  - For W=32, N=13: overflow occurs on the multiply by 2, so Done=Err=1 after edge k+12.
- Not defined: the MAX_N compare at Go is used, as described under Behaviour.
- Non-error Result and latency are identical in both builds.

Test Plan:
- Rst pulse, then idle -> Done=0, Err=0, Busy=0, Result=0.
- Go=1, N=5 at edge k -> Busy high from after edge k to after edge k+4; Done=1, Result=120 (0x78), Err=0 after edge k+5; values held with Go low for 10 cycles.
- N=0, then N=1, then N=12 (W=32) -> Result=1, 1, 479001600 (0x1C8CFC00), each with Err=0.
- N=13 (W=32) -> Done=1, Err=1, Result=0:
  - without macro: after edge k
  - with FACT_CORE_OVF_DETECT_EN: after edge k+12
- Go=1 N=6 then, mid-CALC, Go=1 N=3 -> second request ignored; Result=720. Then Go in DONE with N=3 -> Result=6 after 3 further edges.
- Go=1 N=9, Rst asserted asynchronously between edges k+4 and k+5 -> outputs 0 immediately; state IDLE; no Done. Next Go with N=4 -> Result=24.

Source files
------------

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per cycle, Result = N! held in DONE.
// Optional macro FACT_CORE_OVF_DETECT_EN replaces the MAX_N check with full-product overflow detection.
module fact_core #(
    parameter int W     = 32,
    parameter int NW    = 4,
    parameter int MAX_N = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Go,
    input  logic [NW-1:0] N,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [W-1:0]  Result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  prod_q, prod_d;
    logic          err_q, err_d;

`ifdef FACT_CORE_OVF_DETECT_EN
    // Full-width product; any bit above W-1 means the true factorial no longer fits.
    logic [W+NW-1:0] full_prod;
    assign full_prod = {{NW{1'b0}}, prod_q} * {{W{1'b0}}, cnt_q};
`else
    logic [W-1:0] low_prod;
    assign low_prod = prod_q * {{(W-NW){1'b0}}, cnt_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (Go) begin
                    cnt_d = N;
`ifdef FACT_CORE_OVF_DETECT_EN
                    state_d = CALC;
                    prod_d  = W'(1);
                    err_d   = 1'b0;
`else
                    if (int'(N) > MAX_N) begin
                        state_d = DONE;
                        prod_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        prod_d  = W'(1);
                        err_d   = 1'b0;
                    end
`endif
                end
            end
            CALC: begin
                if (cnt_q <= NW'(1)) begin
                    state_d = DONE;
                end else begin
`ifdef FACT_CORE_OVF_DETECT_EN
                    if (|full_prod[W+NW-1:W]) begin
                        state_d = DONE;
                        prod_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        prod_d = full_prod[W-1:0];
                        cnt_d  = cnt_q - NW'(1);
                    end
`else
                    prod_d = low_prod;
                    cnt_d  = cnt_q - NW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    assign Busy   = (state_q == CALC);
    assign Done   = (state_q == DONE);
    assign Err    = err_q;
    assign Result = prod_q;

endmodule
